// File: rtl/victim_writeback_pkg.sv
// rtl/victim_writeback_pkg.sv - shared types and AXI constants for the victim line writeback engine
package victim_writeback_pkg;

  typedef enum logic [1:0] {IDLE, AW, W, B} wb_state_t;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef logic [31:0] phys_t;
  typedef logic [7:0]  uint8_t;

endpackage

// File: rtl/victim_writeback.sv
// rtl/victim_writeback.sv - drains victim FIFO lines to memory as one incrementing AXI write burst each
// Optional bresp error flag: define VICTIM_WB_BRESP_CHECK_EN to add the sticky wb_error output.
module victim_writeback
  import victim_writeback_pkg::*;
#(
  parameter  int LINE_WIDTH       = 256,
  parameter  int BUS_WIDTH        = 32,
  parameter  int ADDR_WIDTH       = $bits(phys_t),
  localparam int BEATS            = LINE_WIDTH / BUS_WIDTH,
  localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
  localparam int LABEL_WIDTH      = ADDR_WIDTH - LINE_BYTE_OFFSET
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          empty,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] rline,
  output logic                          pop,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [BUS_WIDTH-1:0]          wdata,
  output logic [BUS_WIDTH/8-1:0]        wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
`ifdef VICTIM_WB_BRESP_CHECK_EN
  output logic                          wb_error,
`endif
  output logic                          inflight_valid,
  output logic [LABEL_WIDTH-1:0]        inflight_label,
  output logic                          busy
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef logic [LINE_WIDTH-1:0]  data_t;
  typedef logic [LABEL_WIDTH-1:0] label_t;

  wb_state_t        state, state_next;
  data_t            data_q;
  label_t           label_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = AW;
        end
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) state_next = W;
      end
      W: begin
        wvalid = 1'b1;
        wlast  = (cnt == LAST_BEAT);
        if (wready && wlast) state_next = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The line is buffered at the pop so the FIFO head may change freely afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      label_q <= '0;
      cnt     <= '0;
    end else begin
      if (pop) begin
        label_q <= rline[LINE_WIDTH +: LABEL_WIDTH];
        data_q  <= rline[LINE_WIDTH-1:0];
      end
      if (awvalid && awready)
        cnt <= '0;
      else if (wvalid && wready)
        cnt <= wlast ? '0 : cnt + 1'b1;
    end
  end

  assign awaddr         = {label_q, {LINE_BYTE_OFFSET{1'b0}}};
  assign awlen          = uint8_t'(BEATS - 1);
  assign awsize         = 3'($clog2(BUS_WIDTH / 8));
  assign wdata          = data_q[BUS_WIDTH*int'(cnt) +: BUS_WIDTH];
  assign wstrb          = '1;
  assign busy           = (state != IDLE);
  assign inflight_valid = busy;
  assign inflight_label = label_q;

`ifdef VICTIM_WB_BRESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      wb_error <= 1'b0;
    else if (bvalid && bready && (bresp != BRESP_OKAY))
      wb_error <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
`endif

endmodule
